// File: rtl/ysyx_pkg.sv
// Shared types and helpers for the LSU-to-AXI4-Lite bridge (ysyx_lsu_bus).
package ysyx_pkg;
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE} lsu_bus_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } store_lane_t;

  function automatic logic [2:0] rstrb_to_size(input logic [7:0] strb);
    case (strb)
      8'h01:   return 3'd0;
      8'h03:   return 3'd1;
      default: return 3'd2;
    endcase
  endfunction

  // Bytes pushed past lane 3 are discarded; word-crossing stores are not supported.
  function automatic store_lane_t store_lane(input logic [31:0] data, input logic [3:0] strb,
                                             input logic [1:0] off);
    store_lane_t l;
    l.data = data << {off, 3'b000};
    l.strb = strb << off;
    return l;
  endfunction
endpackage

// File: rtl/ysyx_lsu_bus.sv
// LSU-to-AXI4-Lite master bridge: exactly one bus transaction per level-held LSU request.
// Optional watchdog: define YSYX_LSU_BUS_TIMEOUT_EN to force completion after TIMEOUT_CYC stalled cycles.
module ysyx_lsu_bus
  import ysyx_pkg::*;
#(
  parameter int BIT_W       = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIT_W-1:0] lsu_araddr,
  input  logic             lsu_arvalid,
  input  logic [7:0]       lsu_rstrb,
  output logic [BIT_W-1:0] lsu_rdata,
  output logic             lsu_rvalid,
  input  logic [BIT_W-1:0] lsu_awaddr,
  input  logic             lsu_awvalid,
  input  logic [BIT_W-1:0] lsu_wdata,
  input  logic [7:0]       lsu_wstrb,
  input  logic             lsu_wvalid,
  output logic             lsu_wready,
  output logic             lsu_err,
  output logic [BIT_W-1:0] m_araddr,
  output logic             m_arvalid,
  input  logic             m_arready,
  output logic [2:0]       m_arsize,
  input  logic [BIT_W-1:0] m_rdata,
  input  logic [1:0]       m_rresp,
  input  logic             m_rvalid,
  output logic             m_rready,
  output logic [BIT_W-1:0] m_awaddr,
  output logic             m_awvalid,
  input  logic             m_awready,
  output logic [BIT_W-1:0] m_wdata,
  output logic [3:0]       m_wstrb,
  output logic             m_wvalid,
  input  logic             m_wready,
  input  logic [1:0]       m_bresp,
  input  logic             m_bvalid,
  output logic             m_bready
);
  lsu_bus_state_t   state, next_state;
  logic [BIT_W-1:0] req_addr, req_wdata;
  logic [7:0]       req_strb;
  logic             aw_done, w_done, tmo_hit;
  store_lane_t      lane;

  assign lane     = store_lane(req_wdata, req_strb[3:0], req_addr[1:0]);
  assign m_araddr = {req_addr[BIT_W-1:2], 2'b00};
  assign m_awaddr = {req_addr[BIT_W-1:2], 2'b00};
  assign m_arsize = rstrb_to_size(req_strb);
  assign m_wdata  = lane.data;
  assign m_wstrb  = lane.strb;

`ifdef YSYX_LSU_BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);
  logic [TMO_W-1:0] tmo_cnt;
  logic             busy;

  assign busy    = (state != IDLE) && (state != DONE);
  assign tmo_hit = busy && (tmo_cnt == TMO_LIM);

  // Counts cycles spent in one bus state; any state change restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              tmo_cnt <= '0;
    else if (!busy || next_state != state) tmo_cnt <= '0;
    else                                   tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC != 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    case (state)
      IDLE: begin
        if (lsu_awvalid && lsu_wvalid) next_state = WR_AW;
        else if (lsu_arvalid)          next_state = RD_A;
      end
      RD_A: begin
        m_arvalid = 1'b1;
        if (m_arready) next_state = RD_D;
      end
      RD_D: begin
        m_rready = 1'b1;
        if (m_rvalid) next_state = DONE;
      end
      WR_AW: begin
        m_awvalid = !aw_done;
        m_wvalid  = !w_done;
        if ((aw_done || m_awready) && (w_done || m_wready)) next_state = WR_B;
      end
      WR_B: begin
        m_bready = 1'b1;
        if (m_bvalid) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (tmo_hit) begin
      m_arvalid  = 1'b0;
      m_rready   = 1'b0;
      m_awvalid  = 1'b0;
      m_wvalid   = 1'b0;
      m_bready   = 1'b0;
      next_state = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr   <= '0;
      req_wdata  <= '0;
      req_strb   <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      lsu_rdata  <= '0;
      lsu_rvalid <= 1'b0;
      lsu_wready <= 1'b0;
      lsu_err    <= 1'b0;
    end else begin
      lsu_rvalid <= 1'b0;
      lsu_wready <= 1'b0;
      lsu_err    <= 1'b0;
      if (state == IDLE) begin
        if (lsu_awvalid && lsu_wvalid) begin
          req_addr  <= lsu_awaddr;
          req_wdata <= lsu_wdata;
          req_strb  <= lsu_wstrb;
        end else if (lsu_arvalid) begin
          req_addr <= lsu_araddr;
          req_strb <= lsu_rstrb;
        end
      end
      aw_done <= (state == WR_AW) && (aw_done || (m_awvalid && m_awready));
      w_done  <= (state == WR_AW) && (w_done  || (m_wvalid  && m_wready));
      if (m_rvalid && m_rready) begin
        lsu_rdata  <= m_rdata;
        lsu_rvalid <= 1'b1;
        lsu_err    <= (m_rresp != OKAY);
      end
      if (m_bvalid && m_bready) begin
        lsu_wready <= 1'b1;
        lsu_err    <= (m_bresp != OKAY);
      end
      if (tmo_hit) begin
        if (state == RD_A || state == RD_D) begin
          lsu_rvalid <= 1'b1;
          lsu_rdata  <= '0;
        end else begin
          lsu_wready <= 1'b1;
        end
        lsu_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_lsu_bus.sv
// Scoreboard bench for ysyx_lsu_bus: directed requests against a configurable AXI4-Lite slave model.
module tb_ysyx_lsu_bus;
  import ysyx_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] lsu_araddr, lsu_rdata, lsu_awaddr, lsu_wdata;
  logic        lsu_arvalid, lsu_rvalid, lsu_awvalid, lsu_wvalid, lsu_wready, lsu_err;
  logic [7:0]  lsu_rstrb, lsu_wstrb;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic        m_wvalid, m_wready, m_bvalid, m_bready;
  logic [2:0]  m_arsize;
  logic [1:0]  m_rresp, m_bresp;
  logic [3:0]  m_wstrb;

  ysyx_lsu_bus dut (
    .clk(clk), .rst(rst),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_err(lsu_err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arsize(m_arsize),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  typedef struct { bit is_load; logic [31:0] data; bit err; int lat; int issue; } rsp_t;
  typedef struct { logic [31:0] addr; logic [2:0] size; } ar_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;

  rsp_t        rsp_q[$];
  ar_t         ar_q[$];
  logic [31:0] aw_q[$];
  w_t          w_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Slave knobs
  int          ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0, b_delay = 0;
  logic [31:0] r_data = '0;
  logic [1:0]  r_resp = OKAY, b_resp = OKAY;
  bit          r_silent = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got an unexpected event, expected none (cycle %0d)", name, cyc);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  // AXI4-Lite slave model: ready/valid decided just after each rising edge
  initial begin : slave
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend, aw_got, w_got;
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    {ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend, aw_got, w_got} = '0;
    {ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt} = '0;
    {m_arready, m_rvalid, m_awready, m_wready, m_bvalid} = '0;
    m_rdata = '0; m_rresp = OKAY; m_bresp = OKAY;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        {m_arready, m_rvalid, m_awready, m_wready, m_bvalid} = '0;
        m_rdata = '0; m_rresp = OKAY; m_bresp = OKAY;
        {ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend, aw_got, w_got} = '0;
        {ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt} = '0;
      end else begin
        if (ar_hs && !r_silent) begin r_pend = 1; r_cnt = 0; end
        if (r_hs) r_pend = 0;
        if (aw_hs) aw_got = 1;
        if (w_hs) w_got = 1;
        if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
        if (b_hs) b_pend = 0;

        m_arready = m_arvalid && (ar_cnt >= ar_delay);
        ar_cnt    = (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
        ar_hs     = m_arvalid && m_arready;

        m_rvalid = r_pend && (r_cnt >= r_delay);
        r_cnt    = (r_pend && !m_rvalid) ? r_cnt + 1 : 0;
        m_rdata  = m_rvalid ? r_data : '0;
        m_rresp  = m_rvalid ? r_resp : OKAY;
        r_hs     = m_rvalid && m_rready;

        m_awready = m_awvalid && (aw_cnt >= aw_delay);
        aw_cnt    = (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
        aw_hs     = m_awvalid && m_awready;

        m_wready = m_wvalid && (w_cnt >= w_delay);
        w_cnt    = (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
        w_hs     = m_wvalid && m_wready;

        m_bvalid = b_pend && (b_cnt >= b_delay);
        b_cnt    = (b_pend && !m_bvalid) ? b_cnt + 1 : 0;
        m_bresp  = m_bvalid ? b_resp : OKAY;
        b_hs     = m_bvalid && m_bready;
      end
    end
  end

  // Monitor: pops expectations whenever a handshake or completion pulse is seen
  initial begin : monitor
    bit          p_arv, p_arr;
    logic [31:0] p_ara;
    logic [2:0]  p_ars;
    ar_t         a;
    w_t          w;
    rsp_t        r;
    logic [31:0] aa;
    p_arv = 0; p_arr = 0; p_ara = '0; p_ars = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        p_arv = 0;
      end else begin
        if (m_arvalid && m_arready) begin
          if (ar_q.size() == 0) unexpected("ar_handshake");
          else begin
            a = ar_q.pop_front();
            chk("ar_addr", m_araddr, a.addr);
            chk("ar_size", 32'(m_arsize), 32'(a.size));
          end
        end
        if (p_arv && !p_arr && m_arvalid) begin
          chk("ar_addr_stable", m_araddr, p_ara);
          chk("ar_size_stable", 32'(m_arsize), 32'(p_ars));
        end
        if (m_awvalid && m_awready) begin
          if (aw_q.size() == 0) unexpected("aw_handshake");
          else begin
            aa = aw_q.pop_front();
            chk("aw_addr", m_awaddr, aa);
          end
        end
        if (m_wvalid && m_wready) begin
          if (w_q.size() == 0) unexpected("w_handshake");
          else begin
            w = w_q.pop_front();
            chk("w_data", m_wdata, w.data);
            chk("w_strb", 32'(m_wstrb), 32'(w.strb));
          end
        end
        if (lsu_rvalid || lsu_wready) begin
          chk("pulse_exclusive", 32'(lsu_rvalid && lsu_wready), 32'd0);
          if (rsp_q.size() == 0) unexpected("lsu_response");
          else begin
            r = rsp_q.pop_front();
            chk("rsp_is_load", 32'(lsu_rvalid), 32'(r.is_load));
            if (r.is_load) chk("rsp_rdata", lsu_rdata, r.data);
            chk("rsp_err", 32'(lsu_err), 32'(r.err));
            if (r.lat >= 0) chk("rsp_latency", 32'(cyc - r.issue), 32'(r.lat));
          end
        end
        p_arv = m_arvalid; p_arr = m_arready; p_ara = m_araddr; p_ars = m_arsize;
      end
    end
  end

  task automatic wait_pulse(input bit is_load, input string name);
    int n = 0;
    while (!(is_load ? lsu_rvalid : lsu_wready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no completion pulse in 400 cycles, expected one", name);
    end
  endtask

  task automatic push_ar(input logic [31:0] addr, input logic [2:0] size);
    ar_t a;
    a.addr = addr; a.size = size;
    ar_q.push_back(a);
  endtask

  task automatic push_w(input logic [31:0] awaddr, input logic [31:0] data, input logic [3:0] strb);
    w_t w;
    w.data = data; w.strb = strb;
    aw_q.push_back(awaddr);
    w_q.push_back(w);
  endtask

  task automatic push_rsp(input bit is_load, input logic [31:0] data, input bit err, input int lat);
    rsp_t r;
    r.is_load = is_load; r.data = data; r.err = err; r.lat = lat; r.issue = cyc;
    rsp_q.push_back(r);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [7:0] strb, input logic [31:0] ex_addr,
                         input logic [2:0] ex_size, input logic [31:0] ex_data, input bit ex_err,
                         input int lat);
    push_ar(ex_addr, ex_size);
    push_rsp(1'b1, ex_data, ex_err, lat);
    lsu_araddr = addr; lsu_rstrb = strb; lsu_arvalid = 1'b1;
    wait_pulse(1'b1, "load");
    lsu_arvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb,
                          input logic [31:0] ex_addr, input logic [31:0] ex_data,
                          input logic [3:0] ex_strb, input bit ex_err, input int lat);
    push_w(ex_addr, ex_data, ex_strb);
    push_rsp(1'b0, '0, ex_err, lat);
    lsu_awaddr = addr; lsu_wdata = data; lsu_wstrb = strb;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    wait_pulse(1'b0, "store");
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stimulus
    int n;
    rst = 1'b0;
    lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rstrb = '0;
    lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_m_arvalid", 32'(m_arvalid), 32'd0);
    chk("rst_m_awvalid", 32'(m_awvalid), 32'd0);
    chk("rst_m_wvalid", 32'(m_wvalid), 32'd0);
    chk("rst_m_rready", 32'(m_rready), 32'd0);
    chk("rst_m_bready", 32'(m_bready), 32'd0);
    chk("rst_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
    chk("rst_lsu_wready", 32'(lsu_wready), 32'd0);
    chk("rst_lsu_err", 32'(lsu_err), 32'd0);
    chk("rst_lsu_rdata", lsu_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // halfword load, zero-wait slave
    r_data = 32'hDEADBEEF;
    do_load(32'h80000006, 8'h03, 32'h80000004, 3'd1, 32'hDEADBEEF, 1'b0, 3);

    // byte store into lane 3
    do_store(32'h80000003, 32'h000000AB, 8'h01, 32'h80000000, 32'hAB000000, 4'b1000, 1'b0, 3);

    // W accepted 4 cycles before AW, B two cycles late
    aw_delay = 4; b_delay = 2;
    do_store(32'h80000010, 32'h12345678, 8'h0f, 32'h80000010, 32'h12345678, 4'hf, 1'b0, 9);
    aw_delay = 0; b_delay = 0;

    // AR back-pressure with SLVERR
    ar_delay = 5; r_resp = SLVERR; r_data = 32'hCAFEF00D;
    do_load(32'h80000101, 8'h01, 32'h80000100, 3'd0, 32'hCAFEF00D, 1'b1, 8);
    ar_delay = 0; r_resp = OKAY;

    // halfword store at offset 2 with DECERR
    b_resp = DECERR;
    do_store(32'h80000002, 32'h0000BEEF, 8'h03, 32'h80000000, 32'hBEEF0000, 4'b1100, 1'b1, 3);
    b_resp = OKAY;

    // load and store together: store first, load only after the DONE bubble
    r_data = 32'h55AA1234;
    push_w(32'h80000020, 32'h0000C300, 4'b0010);
    push_ar(32'h80000024, 3'd2);
    push_rsp(1'b0, '0, 1'b0, 3);
    push_rsp(1'b1, 32'h55AA1234, 1'b0, 7);
    lsu_awaddr = 32'h80000021; lsu_wdata = 32'h000000C3; lsu_wstrb = 8'h01;
    lsu_araddr = 32'h80000024; lsu_rstrb = 8'h0f;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1; lsu_arvalid = 1'b1;
    wait_pulse(1'b0, "collide_store");
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    wait_pulse(1'b1, "collide_load");
    lsu_arvalid = 1'b0;
    @(negedge clk);

    // async reset while waiting in RD_D
    r_silent = 1;
    push_ar(32'h80000030, 3'd2);
    lsu_araddr = 32'h80000030; lsu_rstrb = 8'h0f; lsu_arvalid = 1'b1;
    n = 0;
    while (!m_rready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reached_rd_d", 32'(m_rready), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_m_rready", 32'(m_rready), 32'd0);
    chk("arst_m_arvalid", 32'(m_arvalid), 32'd0);
    chk("arst_m_awvalid", 32'(m_awvalid), 32'd0);
    chk("arst_m_wvalid", 32'(m_wvalid), 32'd0);
    chk("arst_m_bready", 32'(m_bready), 32'd0);
    chk("arst_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
    chk("arst_lsu_wready", 32'(lsu_wready), 32'd0);
    chk("arst_lsu_err", 32'(lsu_err), 32'd0);
    chk("arst_lsu_rdata", lsu_rdata, 32'd0);
    lsu_arvalid = 1'b0;
    r_silent = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_m_arvalid", 32'(m_arvalid), 32'd0);
    chk("post_rst_m_rready", 32'(m_rready), 32'd0);

    // normal load after reset release
    r_data = 32'h11223344;
    do_load(32'h80000008, 8'h03, 32'h80000008, 3'd1, 32'h11223344, 1'b0, 3);

`ifdef YSYX_LSU_BUS_TIMEOUT_EN
    // silent R channel: watchdog forces an erroring completion with zero data
    r_silent = 1;
    do_load(32'h8000000C, 8'h0f, 32'h8000000C, 3'd2, 32'h00000000, 1'b1, 258);
    r_silent = 0;
`endif

    repeat (3) @(negedge clk);
    chk("ar_q_empty", 32'(ar_q.size()), 32'd0);
    chk("aw_q_empty", 32'(aw_q.size()), 32'd0);
    chk("w_q_empty", 32'(w_q.size()), 32'd0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
